// File: rtl/cla_seq_adder.sv
// Multi-byte add/subtract sequencer: one 8-bit carry-lookahead slice processes
// NBYTES operand bytes LSB first, chaining the carry through a register.
module cla_seq_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  Sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  Cout,
    output logic                  Ovf
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [NBYTES-1:0][7:0]  a_q;
    logic [NBYTES-1:0][7:0]  b_q;
    logic [NBYTES-1:0][7:0]  res_q;
    logic [CW-1:0]           cnt;
    logic                    carry;

    logic [7:0]              a_byte;
    logic [7:0]              b_byte;
    logic [8:0]              slice_sum;
    logic [8:0]              inc_sum;
    logic                    c_into_msb;

    assign Result = res_q;

    always_comb begin
        a_byte     = a_q[cnt];
        b_byte     = b_q[cnt];
        slice_sum  = {1'b0, a_byte} + {1'b0, b_byte};
        inc_sum    = slice_sum + {8'd0, carry};
        // Carry into bit 7 of this byte, recovered from the sum bit.
        c_into_msb = a_byte[7] ^ b_byte[7] ^ inc_sum[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_q     <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= Sub ? ~B : B;
                        carry    <= Sub;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_q[cnt] <= inc_sum[7:0];
                    carry      <= inc_sum[8];
                    if (cnt == LAST) begin
                        Cout      <= inc_sum[8];
                        Ovf       <= c_into_msb ^ inc_sum[8];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-byte add/subtract sequencer built around one shared 8-bit carry-lookahead add slice, the same slice the `cla_8bit` block provides. It takes one NBYTES-wide operand pair through a valid/ready handshake. It adds the operands one byte per cycle, least-significant byte first, and chains the carry between bytes in a register. It then presents the full-width result, carry-out and signed-overflow flag through a second valid/ready handshake. It sits between a requester (sequencer or ALU front end) and the 8-bit CLA datapath, trading latency for area on wide additions.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2..16; W = 8*NBYTES.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clk.
- in_valid  input  1  requester has a valid operand pair.
- in_ready  output  1  block can accept a pair; high only in IDLE.
- A  input  W  operand A, sampled only on in_valid & in_ready.
- B  input  W  operand B, sampled only on in_valid & in_ready.
- Sub  input  1  0 = A+B, 1 = A-B; sampled with the operands.
- out_valid  output  1  Result, Cout and Ovf are valid.
- out_ready  input  1  consumer accepts the result.
- Result  output  W  sum or difference modulo 2^W.
- Cout  output  1  carry out of bit W-1; for subtract, 1 = no borrow (A >= B unsigned).
- Ovf  output  1  two's-complement overflow: carry into bit W-1 XOR Cout.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture A, B (B inverted if Sub) and Sub into operand registers. Load carry register with Sub. Clear byte counter. Go to RUN.
  - RUN: each cycle, process byte k = counter. Slice computes A[k]+B'[k] giving a 9-bit value; a carry-in incrementer adds the carry register. Write the low 8 bits into Result byte k and bit 8 into the carry register. On the last byte (k = NBYTES-1), also capture the carry into bit 7 as the Ovf source, write Cout, and go to DONE. Otherwise increment the counter.
  - DONE: out_valid=1; Result, Cout and Ovf are held stable. On out_ready go to IDLE. Otherwise stay in DONE.
- Operand registers are not modified in RUN except by the byte-select read. Input ports are ignored outside IDLE.
- Byte counter is ceil(log2(NBYTES)) bits. It never wraps past NBYTES-1; reaching NBYTES-1 forces the exit to DONE.
- Width rules:
  - Incrementer output is 9 bits; the 9-bit slice sum plus carry-in can never exceed 0x1FF.
  - Subtract is A + ~B + 1; no separate subtractor exists.
- Result bytes not yet written in the current operation hold their previous value. Consumers see Result only when out_valid=1.
- No illegal state may lock up: any unused FSM encoding returns to IDLE on the next clock.

## Timing
- Reset values, all forced asynchronously while rst_n=0:
  - state = IDLE, in_ready = 1 (after reset), out_valid = 0
  - Result = 0, Cout = 0, Ovf = 0
  - counter = 0, carry = 0
- Accept edge is cycle 0, when in_valid & in_ready. RUN occupies cycles 1..NBYTES. out_valid rises at cycle NBYTES+1, so latency from accept to out_valid is NBYTES+1 clocks.
- in_ready falls the cycle after accept and returns the cycle after out_valid & out_ready.
- Minimum issue interval is NBYTES+2 cycles, with out_ready held high.
- out_valid & out_ready at edge t: out_valid=0 and in_ready=1 from t+1. A new pair presented at t is not accepted until t+1.
- Backpressure: out_valid stays high and Result, Cout, Ovf stay unchanged for any number of cycles with out_ready=0.
- Reset asserted mid-RUN or in DONE: the operation is discarded and no out_valid pulse is produced. After deassertion the block is in IDLE with the reset values.
- in_valid deasserted before acceptance: no effect; the handshake is not sticky.

## Test plan
- NBYTES=4: A=0xFFFFFFFF, B=0x00000001, Sub=0 -> Result=0x00000000, Cout=1, Ovf=0. out_valid exactly 5 cycles after accept.
- A=0x7FFFFFFF, B=0x00000001, Sub=0 -> Result=0x80000000, Cout=0, Ovf=1. Then A=0x00000005, B=0x00000007, Sub=1 -> Result=0xFFFFFFFE, Cout=0, Ovf=0.
- A=0x80000000, B=0x00000001, Sub=1 -> Result=0x7FFFFFFF, Cout=1, Ovf=1. Carry ripple: A=0x00FF00FF, B=0x00010001 -> Result=0x01000100, Cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid, Result, Cout, Ovf constant; in_ready=0 throughout. in_valid pulses during RUN/DONE are ignored, with no second capture.
- Reset: pulse rst_n low during RUN cycle 2 -> outputs immediately 0, no out_valid. The next transaction 0x12345678+0x11111111 gives Result=0x23456789, Cout=0.
- Back-to-back with in_valid and out_ready tied high, 100 random pairs, NBYTES=2 and NBYTES=4 -> every result matches a W+1-bit reference model. Issue interval is exactly NBYTES+2 cycles.
